// File: rtl/photo_reader_xmtr_pkg.sv
// Shared types and frame classification for the photoelectric tape reader emulation.
package photo_pkg;

   typedef logic [4:0] frame_t;

   localparam frame_t FRAME_BLANK = 5'b00000;
   localparam frame_t STOP_MASK   = 5'b10111;
   localparam frame_t STOP_VAL    = 5'b00100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SLOT = 2'd1,
      ST_HALT = 2'd2
   } rdr_state_t;

   // Stop code ignores bit3, so both 5'b00100 and 5'b01100 halt the reader.
   function automatic logic is_stop(input frame_t f);
      return (f & STOP_MASK) == STOP_VAL;
   endfunction

endpackage

// File: rtl/photo_reader_xmtr_sync_fifo.sv
// Single-clock FIFO with synchronous flush; pointers wrap naturally (DEPTH is a power of 2).
module sync_fifo #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  logic [WIDTH-1:0]         i_din,
   output logic [WIDTH-1:0]         o_dout,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rd_ptr];

   // Flush wins over both push and pop: a frame offered during flush is dropped.
   assign w_push = i_push && !o_full  && !i_flush;
   assign w_pop  = i_pop  && !o_empty && !i_flush;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/photo_reader_xmtr.sv
// G-15 photo tape reader transmitter: buffers host frames and replays them as
// timed PHOTO1..PHOTO5 strobes, one frame per character slot, halting on a stop code.
module photo_reader_xmtr
   import photo_pkg::*;
#(
   parameter int FIFO_DEPTH    = 16,
   parameter int CHAR_PERIOD   = 400,
   parameter int STROBE_OFFSET = 100,
   parameter int STROBE_LEN    = 8
) (
   input  logic                          CLOCK,
   input  logic                          rst_n,
   input  frame_t                        frame_data,
   input  logic                          frame_valid,
   output logic                          frame_ready,
   input  logic                          RUN,
   input  logic                          flush,
   output logic                          PHOTO1,
   output logic                          PHOTO2,
   output logic                          PHOTO3,
   output logic                          PHOTO4,
   output logic                          PHOTO5,
   output logic                          READER_BUSY,
   output logic                          STOP_SEEN,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int CW = (CHAR_PERIOD > 1) ? $clog2(CHAR_PERIOD) : 1;
   // One extra bit so OFFSET+LEN == CHAR_PERIOD still fits for comparison.
   localparam logic [CW:0] SLOT_LAST = (CW+1)'(CHAR_PERIOD - 1);
   localparam logic [CW:0] STB_LO    = (CW+1)'(STROBE_OFFSET);
   localparam logic [CW:0] STB_HI    = (CW+1)'(STROBE_OFFSET + STROBE_LEN);

   rdr_state_t    r_state;
   logic [CW-1:0] r_cnt;
   frame_t        r_hold;

   frame_t        w_fifo_dout;
   logic          w_fifo_full;
   logic          w_fifo_empty;
   logic          w_pop;
   logic          w_start;
   logic          w_slot_end;
   logic          w_strobe;
   logic [CW:0]   w_cnt_x;

   sync_fifo #(
      .WIDTH (5),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (CLOCK),
      .rst_n   (rst_n),
      .i_push  (frame_valid),
      .i_pop   (w_pop),
      .i_flush (flush),
      .i_din   (frame_data),
      .o_dout  (w_fifo_dout),
      .o_count (fifo_count),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   assign frame_ready = !w_fifo_full;

   assign w_cnt_x    = {1'b0, r_cnt};
   assign w_start    = RUN && !w_fifo_empty;
   assign w_slot_end = (r_state == ST_SLOT) && (w_cnt_x == SLOT_LAST);
   assign w_pop      = ((r_state == ST_IDLE) && w_start) ||
                       (w_slot_end && !is_stop(r_hold) && w_start);

   always_ff @(posedge CLOCK) begin
      if (w_pop) r_hold <= w_fifo_dout;
   end

   always_ff @(posedge CLOCK or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (w_start) r_state <= ST_SLOT;
            end
            ST_SLOT: begin
               if (w_slot_end) begin
                  r_cnt <= '0;
                  if (is_stop(r_hold))  r_state <= ST_HALT;
                  else if (w_start)     r_state <= ST_SLOT;
                  else                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_HALT: begin
               r_cnt <= '0;
               if (!RUN) r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Outputs decode from state, so an async reset drops the strobe immediately.
   assign w_strobe = (r_state == ST_SLOT) && (w_cnt_x >= STB_LO) && (w_cnt_x < STB_HI);
   assign {PHOTO5, PHOTO4, PHOTO3, PHOTO2, PHOTO1} = w_strobe ? r_hold : FRAME_BLANK;
   assign READER_BUSY = (r_state == ST_SLOT);
   assign STOP_SEEN   = w_slot_end && is_stop(r_hold);

endmodule

// File: doc/photo_reader_xmtr.md
Name: photo_reader_xmtr

Overview:
- Emulates the G-15 photoelectric tape reader as the transmitting end of the PHOTO1..PHOTO5 input lines consumed by the I/O register logic.
- The host or SD loader pushes 5-bit tape frames into an internal FIFO.
- While the machine enables the reader, the block replays the frames as timed strobe pulses, one frame per character slot.
- Reading halts after a stop frame is strobed, as the real reader halts on a stop code.

Parameters:
- FIFO_DEPTH, 16: frame buffer depth; must be a power of 2, at least 2.
- CHAR_PERIOD, 400: CLOCK cycles per character slot.
- STROBE_OFFSET, 100: cycles from slot start to strobe assertion.
- STROBE_LEN, 8: strobe width in cycles. Requires STROBE_OFFSET + STROBE_LEN <= CHAR_PERIOD and STROBE_LEN >= 1.

Ports:
- CLOCK, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- frame_data, input, 5: tape frame; bit0 maps to PHOTO1 … bit4 maps to PHOTO5.
- frame_valid, input, 1: host offers frame_data.
- frame_ready, output, 1: FIFO can accept a frame.
- RUN, input, 1: reader enable from the I/O control (photo-read command active).
- flush, input, 1: synchronous FIFO clear.
- PHOTO1..PHOTO5, output, 1 each: strobed frame bits.
- READER_BUSY, output, 1: a character slot is in progress.
- STOP_SEEN, output, 1: one-cycle pulse at the end of a stop-frame slot.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset values: all outputs 0, except frame_ready = 1. FIFO is empty, FSM is in IDLE, slot counter is 0.
- FIFO write:
  - A frame is accepted on frame_valid & frame_ready.
  - frame_ready = (fifo_count < FIFO_DEPTH).
  - A push with no pop on a full FIFO cannot occur, because ready is low.
- Simultaneous push and pop: count is unchanged; a push into an empty FIFO is poppable the next cycle.
- Frame classes:
  - BLANK: 5'b00000.
  - STOP: bit4=0, bit2=1, bit1=0, bit0=0, bit3 don't-care, i.e. 5'b00100 or 5'b01100.
  - DATA: all others.
- FSM states: IDLE, SLOT, HALT.
- IDLE -> SLOT:
  - Taken when RUN=1 and fifo_count != 0.
  - The frame is popped into a holding register on the transition cycle.
  - READER_BUSY=1 from the next cycle.
  - The slot counter resets to 0.
- SLOT:
  - The counter increments every cycle.
  - PHOTOn = held bit n-1 while STROBE_OFFSET <= counter < STROBE_OFFSET+STROBE_LEN; otherwise all PHOTO lines are 0.
  - BLANK frames occupy the slot with no pulses.
  - At counter = CHAR_PERIOD-1 the slot ends.
- End of slot:
  - STOP frame: pulse STOP_SEEN for one cycle and go to HALT.
  - Otherwise, if RUN=1 and the FIFO is non-empty: pop the next frame and start a new SLOT back-to-back, with no idle cycle and READER_BUSY staying 1.
  - Otherwise go to IDLE; READER_BUSY=0.
- HALT:
  - READER_BUSY=0.
  - Return to IDLE only after RUN is sampled 0.
  - A stop code therefore requires a new read command, i.e. RUN deasserting and re-asserting.
- RUN falling mid-slot: the current slot completes in full, with the strobe intact; then the FSM goes to IDLE.
- flush:
  - Empties the FIFO the same cycle; a concurrent push is dropped.
  - Does not abort an in-progress slot.
- Async reset mid-slot: PHOTO lines drop immediately, and the FIFO and FSM clear.
- Width rules:
  - Slot counter width is $clog2(CHAR_PERIOD).
  - FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - Count is one bit wider than the pointers to represent the full state.

Decomposition:
- Shared package photo_pkg:
  - frame_t (logic [4:0]).
  - Constants FRAME_BLANK and STOP_MASK/STOP_VAL (mask 5'b10111, value 5'b00100).
  - Function is_stop().
  - FSM state enum rdr_state_t.
- One sub-module: sync_fifo, parameterised on width and depth, with push/pop/flush/count.
- Slot timing and the FSM stay in the top module.

Test Plan (CHAR_PERIOD=20, STROBE_OFFSET=5, STROBE_LEN=3, FIFO_DEPTH=4):
- Basic strobe: push 5'b10011, then raise RUN.
  - READER_BUSY rises one cycle after RUN.
  - PHOTO1, PHOTO2 and PHOTO5 are high for exactly 3 cycles, starting 5 cycles into the slot.
  - IDLE at slot end.
- Back-to-back, FIFO full: push 4 DATA frames with RUN=1.
  - Push 4 frames: frame_ready drops at count 4.
  - Strobes are exactly 20 cycles apart.
  - READER_BUSY is continuously high for 80 cycles.
- Stop code: push 5'b00001, 5'b01100, 5'b00010 with RUN held.
  - Two slots, then a one-cycle STOP_SEEN; 5'b00010 remains, fifo_count=1.
  - Lower then re-raise RUN: the third frame strobes.
- Blank frame and simultaneous push/pop: push 5'b00000.
  - A 20-cycle slot runs with PHOTO lines all 0.
  - A push on the same cycle as the pop keeps count unchanged.
- RUN dropped mid-slot: deassert RUN at slot cycle 3.
  - Strobe still occurs at cycles 5-7.
  - FSM goes to IDLE with 2 frames left unpopped.
- Reset mid-strobe and flush:
  - rst_n low at slot cycle 6: PHOTO lines go to 0 asynchronously, fifo_count=0, frame_ready=1.
  - flush with 3 frames queued gives count 0 the next cycle.
